// File: rtl/pwm_audio_pkg.sv
// pwm_audio_pkg: shared constants for the multi-channel PWM/PDM audio block.
//   MODE_PWM / MODE_PDM : encoding of the i_mode input
//   DW_DEF / NCH_DEF / CW_DEF : default sample width, channel count, timer width
package pwm_audio_pkg;

   typedef enum logic {
      MODE_PWM = 1'b0,
      MODE_PDM = 1'b1
   } mode_e;

   localparam int DW_DEF  = 8;
   localparam int NCH_DEF = 2;
   localparam int CW_DEF  = 16;

endpackage

// File: rtl/pwm_audio_chan.sv
// pwm_audio_chan: one audio output channel.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_clr          : clears accumulator and output (mode change)
//   i_mode         : 0 = PWM compare, 1 = first-order sigma-delta
//   i_cnt          : shared free-running PWM counter
//   i_act          : active sample for this channel
//   o_pwm          : registered 1-bit output
module pwm_audio_chan
   import pwm_audio_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_clr,
   input  logic          i_mode,
   input  logic [DW-1:0] i_cnt,
   input  logic [DW-1:0] i_act,
   output logic          o_pwm
);

   logic [DW-1:0] acc_q, acc_d;
   logic          pwm_q, pwm_d;
   logic [DW:0]   sum;

   always_comb begin
      // Carry out of the DW-bit accumulator is the PDM bit; its density is act/2^DW.
      sum   = {1'b0, acc_q} + {1'b0, i_act};
      acc_d = sum[DW-1:0];
      pwm_d = (i_mode == MODE_PDM) ? sum[DW] : (i_cnt < i_act);
      if (i_clr) begin
         acc_d = '0;
         pwm_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         acc_q <= '0;
         pwm_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         pwm_q <= pwm_d;
      end
   end

   assign o_pwm = pwm_q;

endmodule

// File: rtl/pwm_audio_mc.sv
// pwm_audio_mc: multi-channel PWM / PDM audio output with a sample-period timer
// and a one-deep frame buffer.
//   i_clk, i_reset      : clock, synchronous active-high reset
//   i_mode              : 0 = PWM, 1 = PDM
//   i_reload            : sample period in clocks minus 1
//   i_valid / o_ready   : frame handshake, accept on i_valid && o_ready
//   i_data              : NCH offset-binary samples, channel 0 in the LSBs
//   i_clr_underflow     : clears the sticky underflow flag
//   o_pwm               : registered 1-bit output per channel
//   o_sample_stb        : one-cycle pulse, one clock after each period boundary
//   o_underflow         : sticky, a boundary passed with no pending frame
module pwm_audio_mc
   import pwm_audio_pkg::*;
#(
   parameter int DW  = DW_DEF,
   parameter int NCH = NCH_DEF,
   parameter int CW  = CW_DEF
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_mode,
   input  logic [CW-1:0]     i_reload,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [NCH*DW-1:0] i_data,
   input  logic              i_clr_underflow,
   output logic [NCH-1:0]    o_pwm,
   output logic              o_sample_stb,
   output logic              o_underflow
);

   logic [CW-1:0]     timer_q, timer_d;
   logic              stb_q;
   logic [NCH*DW-1:0] pend_q, pend_d;
   logic [NCH*DW-1:0] act_q, act_d;
   logic              pend_full_q, pend_full_d;
   logic              armed_q, armed_d;
   logic              uf_q, uf_d;
   logic              mode_q;
   logic [DW-1:0]     cnt_q, cnt_d;
   logic              tick, accept, mode_chg;

   always_comb begin
      tick     = (timer_q == '0);
      timer_d  = tick ? i_reload : timer_q - 1'b1;
      accept   = i_valid && !pend_full_q;
      mode_chg = (i_mode != mode_q);
      cnt_d    = mode_chg ? '0 : cnt_q + 1'b1;

      pend_d      = pend_q;
      pend_full_d = pend_full_q;
      act_d       = act_q;
      armed_d     = armed_q;
      uf_d        = uf_q;

      if (i_clr_underflow)
         uf_d = 1'b0;
      // A boundary either promotes the pending frame or, once armed, flags
      // underflow; the set is applied after the clear so it wins.
      if (tick) begin
         if (pend_full_q) begin
            act_d       = pend_q;
            pend_full_d = 1'b0;
         end else if (armed_q) begin
            uf_d = 1'b1;
         end
      end
      // accept implies !pend_full_q, so it never collides with a promotion.
      if (accept) begin
         pend_d      = i_data;
         pend_full_d = 1'b1;
         armed_d     = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         timer_q     <= '0;
         stb_q       <= 1'b0;
         pend_q      <= '0;
         act_q       <= '0;
         pend_full_q <= 1'b0;
         armed_q     <= 1'b0;
         uf_q        <= 1'b0;
         mode_q      <= i_mode;
         cnt_q       <= '0;
      end else begin
         timer_q     <= timer_d;
         stb_q       <= tick;
         pend_q      <= pend_d;
         act_q       <= act_d;
         pend_full_q <= pend_full_d;
         armed_q     <= armed_d;
         uf_q        <= uf_d;
         mode_q      <= i_mode;
         cnt_q       <= cnt_d;
      end
   end

   for (genvar c = 0; c < NCH; c++) begin : g_chan
      pwm_audio_chan #(.DW(DW)) u_chan (
         .i_clk   (i_clk),
         .i_reset (i_reset),
         .i_clr   (mode_chg),
         .i_mode  (mode_q),
         .i_cnt   (cnt_q),
         .i_act   (act_q[c*DW +: DW]),
         .o_pwm   (o_pwm[c])
      );
   end

   assign o_ready      = !pend_full_q;
   assign o_sample_stb = stb_q;
   assign o_underflow  = uf_q;

endmodule
